gf180mcu_fd_sc_mcu9t5v0__xnor_prbs7_chk: RTL

GF180MCU_FD_SC_MCU9T5V0__XNOR_PRBS7_CHK -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__xnor_prbs7_chk

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__xnor_prbs7_chk.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__xnor_prbs7_chk.sv
// PRBS7 (x^7+x^6+1, XNOR feedback) serial stream checker with lock detection,
// single-error pulses and a saturating error counter.
module gf180mcu_fd_sc_mcu9t5v0__xnor_prbs7_chk #(
  parameter int unsigned LOCK_CNT = 16,
  parameter int unsigned LOSS_CNT = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             D,
  input  logic             CLR,
  output logic             LOCK,
  output logic             ERR,
  output logic [CNT_W-1:0] ERRCNT
);

  localparam int unsigned FILL_W  = 3;
  localparam int unsigned MATCH_W = 8;
  localparam int unsigned CONS_W  = 4;
  localparam logic [FILL_W-1:0]  FILL_LAST = FILL_W'(6);
  localparam logic [MATCH_W:0]   LOCK_TGT  = (MATCH_W+1)'(LOCK_CNT);
  localparam logic [CONS_W:0]    LOSS_TGT  = (CONS_W+1)'(LOSS_CNT);
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SEEK   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [6:0]         h_q, h_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [CONS_W-1:0]  cons_q, cons_d;
  logic               lock_q, lock_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   errcnt_q, errcnt_d;

  logic               pred_c;
  logic               seek_miss_c;
  logic [MATCH_W:0]   match_inc_c;
  logic [CONS_W:0]    cons_inc_c;

  // All-ones history is the XNOR lock-up state and can never match a real stream.
  assign pred_c      = ~(h_q[6] ^ h_q[5]);
  assign seek_miss_c = (D != pred_c) || (h_q == 7'h7F);
  assign match_inc_c = {1'b0, match_q} + (MATCH_W+1)'(1);
  assign cons_inc_c  = {1'b0, cons_q} + (CONS_W+1)'(1);

  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    fill_d   = fill_q;
    match_d  = match_q;
    cons_d   = cons_q;
    lock_d   = lock_q;
    err_d    = 1'b0;
    errcnt_d = errcnt_q;

    if (EN) begin
      unique case (state_q)
        FILL: begin
          h_d = {h_q[5:0], D};
          if (fill_q == FILL_LAST) begin
            fill_d  = '0;
            state_d = SEEK;
          end else begin
            fill_d = fill_q + FILL_W'(1);
          end
        end
        SEEK: begin
          h_d = {h_q[5:0], D};
          if (seek_miss_c) begin
            match_d = '0;
          end else if (match_inc_c == LOCK_TGT) begin
            match_d = '0;
            state_d = LOCKED;
            lock_d  = 1'b1;
          end else begin
            match_d = match_inc_c[MATCH_W-1:0];
          end
        end
        LOCKED: begin
          // Self-generated history keeps one line error from causing a second miss.
          h_d = {h_q[5:0], pred_c};
          if (D != pred_c) begin
            err_d = 1'b1;
            if (errcnt_q != CNT_MAX) errcnt_d = errcnt_q + CNT_W'(1);
            if (cons_inc_c == LOSS_TGT) begin
              state_d = FILL;
              lock_d  = 1'b0;
              fill_d  = '0;
              match_d = '0;
              cons_d  = '0;
            end else begin
              cons_d = cons_inc_c[CONS_W-1:0];
            end
          end else begin
            cons_d = '0;
          end
        end
        default: begin
          state_d = FILL;
          lock_d  = 1'b0;
        end
      endcase
    end

    if (CLR) errcnt_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= FILL;
      h_q      <= '0;
      fill_q   <= '0;
      match_q  <= '0;
      cons_q   <= '0;
      lock_q   <= 1'b0;
      err_q    <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      cons_q   <= cons_d;
      lock_q   <= lock_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign LOCK   = lock_q;
  assign ERR    = err_q;
  assign ERRCNT = errcnt_q;

endmodule
